// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the IF-stage control and the PC sequencer.
// The master drives redirect requests and stall; the slave owns the PC.
interface pc_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 16,
  parameter int JIDX_W = 26,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              exc_valid;
  logic [ADDR_W-1:0] exc_vector;
  logic              br_valid;
  logic              br_taken;
  logic [ADDR_W-1:0] br_base;
  logic [IMM_W-1:0]  br_imm;
  logic              jr_valid;
  logic [ADDR_W-1:0] jr_target;
  logic              j_valid;
  logic [ADDR_W-1:0] j_base;
  logic [JIDX_W-1:0] j_index;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic              redirect;
  logic              pending;
  logic              misalign;
  logic [CNT_W-1:0]  redirect_cnt;

  modport master (
    output stall, exc_valid, exc_vector, br_valid, br_taken, br_base, br_imm,
           jr_valid, jr_target, j_valid, j_base, j_index,
    input  pc, pc_plus, redirect, pending, misalign, redirect_cnt
  );

  modport slave (
    input  stall, exc_valid, exc_vector, br_valid, br_taken, br_base, br_imm,
           jr_valid, jr_target, j_valid, j_base, j_index,
    output pc, pc_plus, redirect, pending, misalign, redirect_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC register and next-PC selection,
// holds on stall, latches one redirect across a stall, flags misaligned jr
// targets and counts applied redirects.
//
// state    | meaning
// ST_RUN   | no redirect latched
// ST_PEND  | a redirect target is latched, waiting for stall to drop
module pc_sequencer #(
  parameter int                  ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter int                  STEP     = 4,
  parameter int                  IMM_W    = 16,
  parameter int                  JIDX_W   = 26,
  parameter int                  CNT_W    = 16
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic {ST_RUN = 1'b0, ST_PEND = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_pend_tgt, w_pend_tgt_nxt;
  logic              r_pend_mis, w_pend_mis_nxt;
  logic              r_redirect, r_misalign;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_load, w_load_mis;

  logic [ADDR_W-1:0] w_br_tgt, w_j_tgt, w_jr_tgt, w_pc_plus;
  logic              w_jr_mis;
  logic              w_req;
  logic [ADDR_W-1:0] w_req_tgt;
  logic              w_req_mis;
  logic              w_unused_ok;

  assign w_pc_plus = r_pc + ADDR_W'(STEP);
  assign w_br_tgt  = bus.br_base + ({{(ADDR_W-IMM_W){bus.br_imm[IMM_W-1]}}, bus.br_imm} << 2);
  // ADDR_W must exceed JIDX_W+2 so the region bits from j_base are non-empty.
  assign w_j_tgt   = {bus.j_base[ADDR_W-1:JIDX_W+2], bus.j_index, 2'b00};
  assign w_jr_tgt  = {bus.jr_target[ADDR_W-1:2], 2'b00};
  assign w_jr_mis  = |bus.jr_target[1:0];
  // Low bits of j_base are replaced by the index and never consumed.
  assign w_unused_ok = ^bus.j_base[JIDX_W+1:0];

  // Pick the highest-priority new request this cycle.
  always_comb begin
    w_req     = 1'b1;
    w_req_tgt = bus.exc_vector;
    w_req_mis = 1'b0;
    if (bus.exc_valid) begin
      w_req_tgt = bus.exc_vector;
    end else if (bus.br_valid && bus.br_taken) begin
      w_req_tgt = w_br_tgt;
    end else if (bus.jr_valid) begin
      w_req_tgt = w_jr_tgt;
      w_req_mis = w_jr_mis;
    end else if (bus.j_valid) begin
      w_req_tgt = w_j_tgt;
    end else begin
      w_req = 1'b0;
    end
  end

  // Next-state, next-PC and latch update.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_tgt_nxt = r_pend_tgt;
    w_pend_mis_nxt = r_pend_mis;
    w_load         = 1'b0;
    w_load_mis     = 1'b0;
    if (!bus.stall) begin
      if (bus.exc_valid) begin
        w_pc_nxt    = bus.exc_vector;
        w_load      = 1'b1;
        w_state_nxt = ST_RUN;
      end else if (r_state == ST_PEND) begin
        // Older latched redirect beats anything arriving now.
        w_pc_nxt    = r_pend_tgt;
        w_load      = 1'b1;
        w_load_mis  = r_pend_mis;
        w_state_nxt = ST_RUN;
      end else if (w_req) begin
        w_pc_nxt   = w_req_tgt;
        w_load     = 1'b1;
        w_load_mis = w_req_mis;
      end else begin
        w_pc_nxt = w_pc_plus;
      end
    end else if (w_req && (r_state == ST_RUN || bus.exc_valid)) begin
      w_pend_tgt_nxt = w_req_tgt;
      w_pend_mis_nxt = w_req_mis;
      w_state_nxt    = ST_PEND;
    end
  end

  // State, PC, latch and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_pend_tgt <= '0;
      r_pend_mis <= 1'b0;
      r_redirect <= 1'b0;
      r_misalign <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
      r_pend_mis <= w_pend_mis_nxt;
      r_redirect <= w_load;
      r_misalign <= w_load_mis;
      if (w_load && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.pc           = r_pc;
  assign bus.pc_plus      = w_pc_plus;
  assign bus.redirect     = r_redirect;
  assign bus.pending      = (r_state == ST_PEND);
  assign bus.misalign     = r_misalign;
  assign bus.redirect_cnt = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 16-bit-counter instance and a 2-bit-counter
// instance share the same stimulus so saturation can be observed.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(32), .IMM_W(16), .JIDX_W(26), .CNT_W(16)) bus ();
  pc_sequencer_if #(.ADDR_W(32), .IMM_W(16), .JIDX_W(26), .CNT_W(2))  bus2 ();

  assign bus2.stall      = bus.stall;
  assign bus2.exc_valid  = bus.exc_valid;
  assign bus2.exc_vector = bus.exc_vector;
  assign bus2.br_valid   = bus.br_valid;
  assign bus2.br_taken   = bus.br_taken;
  assign bus2.br_base    = bus.br_base;
  assign bus2.br_imm     = bus.br_imm;
  assign bus2.jr_valid   = bus.jr_valid;
  assign bus2.jr_target  = bus.jr_target;
  assign bus2.j_valid    = bus.j_valid;
  assign bus2.j_base     = bus.j_base;
  assign bus2.j_index    = bus.j_index;

  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0), .STEP(4), .IMM_W(16), .JIDX_W(26), .CNT_W(16))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0), .STEP(4), .IMM_W(16), .JIDX_W(26), .CNT_W(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic clear_inputs();
    bus.stall = 0; bus.exc_valid = 0; bus.exc_vector = '0;
    bus.br_valid = 0; bus.br_taken = 0; bus.br_base = '0; bus.br_imm = '0;
    bus.jr_valid = 0; bus.jr_target = '0;
    bus.j_valid = 0; bus.j_base = '0; bus.j_index = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    clear_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h want=%h", bus.pc, 32'h0); end
    checks++; if (bus.redirect !== 1'b0 || bus.pending !== 1'b0 || bus.misalign !== 1'b0) begin
      failures++; $display("FAIL reset_flags got=%b%b%b want=000", bus.redirect, bus.pending, bus.misalign); end
    checks++; if (bus.redirect_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", bus.redirect_cnt); end
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 32'h4;
      checks++; if (bus.pc !== exp_pc || bus.redirect !== 1'b0) begin
        failures++; $display("FAIL seq_pc got=%h/%b want=%h/0", bus.pc, bus.redirect, exp_pc); end
      checks++; if (bus.pc_plus !== exp_pc + 32'h4) begin
        failures++; $display("FAIL seq_pc_plus got=%h want=%h", bus.pc_plus, exp_pc + 32'h4); end
    end
  endtask

  task automatic test_branch();
    bus.br_valid = 1; bus.br_taken = 1; bus.br_base = 32'h100; bus.br_imm = 16'hFFFE;
    step();
    clear_inputs();
    checks++; if (bus.pc !== 32'hF8 || bus.redirect !== 1'b1) begin
      failures++; $display("FAIL br_taken got=%h/%b want=000000f8/1", bus.pc, bus.redirect); end
    checks++; if (bus.redirect_cnt !== 16'd1) begin failures++; $display("FAIL br_cnt got=%0d want=1", bus.redirect_cnt); end
    step();
    checks++; if (bus.pc !== 32'hFC || bus.redirect !== 1'b0) begin
      failures++; $display("FAIL br_after got=%h/%b want=000000fc/0", bus.pc, bus.redirect); end
    bus.br_valid = 1; bus.br_taken = 0; bus.br_base = 32'h100; bus.br_imm = 16'hFFFE;
    step();
    clear_inputs();
    checks++; if (bus.pc !== 32'h100 || bus.redirect !== 1'b0) begin
      failures++; $display("FAIL br_not_taken got=%h/%b want=00000100/0", bus.pc, bus.redirect); end
  endtask

  task automatic test_priority();
    bus.exc_valid = 1; bus.exc_vector = 32'h8000_0180;
    bus.br_valid = 1; bus.br_taken = 1; bus.br_base = 32'h100; bus.br_imm = 16'h0004;
    bus.j_valid = 1; bus.j_base = 32'h4000_0010; bus.j_index = 26'h10;
    step();
    clear_inputs();
    checks++; if (bus.pc !== 32'h8000_0180 || bus.redirect !== 1'b1) begin
      failures++; $display("FAIL prio_exc got=%h/%b want=80000180/1", bus.pc, bus.redirect); end
    bus.j_valid = 1; bus.j_base = 32'h4000_0010; bus.j_index = 26'h10;
    step();
    clear_inputs();
    checks++; if (bus.pc !== 32'h4000_0040) begin failures++; $display("FAIL j_target got=%h want=40000040", bus.pc); end
    bus.jr_valid = 1; bus.jr_target = 32'h501;
    bus.j_valid = 1; bus.j_base = 32'h0; bus.j_index = 26'h7;
    step();
    clear_inputs();
    checks++; if (bus.pc !== 32'h500 || bus.misalign !== 1'b1) begin
      failures++; $display("FAIL jr_over_j got=%h/%b want=00000500/1", bus.pc, bus.misalign); end
    checks++; if (bus.redirect_cnt !== 16'd4) begin failures++; $display("FAIL prio_cnt got=%0d want=4", bus.redirect_cnt); end
    step();
    checks++; if (bus.pc !== 32'h504 || bus.misalign !== 1'b0 || bus.redirect !== 1'b0) begin
      failures++; $display("FAIL jr_after got=%h/%b%b want=00000504/00", bus.pc, bus.misalign, bus.redirect); end
  endtask

  task automatic test_stall_exc_overwrite();
    bus.stall = 1; bus.jr_valid = 1; bus.jr_target = 32'h2003;
    step();
    checks++; if (bus.pending !== 1'b1 || bus.pc !== 32'h504) begin
      failures++; $display("FAIL st4_latch got=%b/%h want=1/00000504", bus.pending, bus.pc); end
    bus.jr_valid = 0; bus.j_valid = 1; bus.j_base = 32'h0; bus.j_index = 26'h20;
    step();
    checks++; if (bus.pc !== 32'h504 || bus.redirect !== 1'b0) begin
      failures++; $display("FAIL st4_hold got=%h/%b want=00000504/0", bus.pc, bus.redirect); end
    bus.j_valid = 0; bus.exc_valid = 1; bus.exc_vector = 32'h8000_0180;
    step();
    clear_inputs();
    step();
    checks++; if (bus.pc !== 32'h8000_0180 || bus.pending !== 1'b0) begin
      failures++; $display("FAIL st4_release got=%h/%b want=80000180/0", bus.pc, bus.pending); end
    checks++; if (bus.misalign !== 1'b0 || bus.redirect !== 1'b1) begin
      failures++; $display("FAIL st4_flags got=%b%b want=0/1", bus.misalign, bus.redirect); end
  endtask

  task automatic test_stall_jr_release();
    bus.stall = 1; bus.jr_valid = 1; bus.jr_target = 32'h2003;
    step();
    bus.jr_valid = 0;
    step(); step();
    checks++; if (bus.pc !== 32'h8000_0180 || bus.pending !== 1'b1 || bus.misalign !== 1'b0) begin
      failures++; $display("FAIL st5_hold got=%h/%b/%b want=80000180/1/0", bus.pc, bus.pending, bus.misalign); end
    bus.stall = 0; bus.j_valid = 1; bus.j_base = 32'h0; bus.j_index = 26'h40;
    step();
    clear_inputs();
    checks++; if (bus.pc !== 32'h2000 || bus.misalign !== 1'b1 || bus.redirect !== 1'b1) begin
      failures++; $display("FAIL st5_release got=%h/%b%b want=00002000/11", bus.pc, bus.misalign, bus.redirect); end
    checks++; if (bus.redirect_cnt !== 16'd6 || bus2.redirect_cnt !== 2'd3) begin
      failures++; $display("FAIL st5_cnt got=%0d/%0d want=6/3", bus.redirect_cnt, bus2.redirect_cnt); end
    step();
    checks++; if (bus.pc !== 32'h2004 || bus.misalign !== 1'b0 || bus.redirect !== 1'b0) begin
      failures++; $display("FAIL st5_after got=%h/%b%b want=00002004/00", bus.pc, bus.misalign, bus.redirect); end
  endtask

  task automatic test_async_reset_sat_wrap();
    bus.stall = 1; bus.jr_valid = 1; bus.jr_target = 32'h3000;
    step();
    clear_inputs();
    bus.stall = 1;
    #2;
    rst_n = 0;
    #1;
    checks++; if (bus.pc !== 32'h0 || bus.pending !== 1'b0 || bus.redirect_cnt !== 16'd0) begin
      failures++; $display("FAIL async_rst got=%h/%b/%0d want=00000000/0/0", bus.pc, bus.pending, bus.redirect_cnt); end
    step();
    rst_n = 1;
    bus.stall = 0;
    step();
    checks++; if (bus.pc !== 32'h4 || bus.redirect !== 1'b0) begin
      failures++; $display("FAIL rst_discard got=%h/%b want=00000004/0", bus.pc, bus.redirect); end
    for (int i = 0; i < 5; i++) begin
      bus.exc_valid = 1; bus.exc_vector = 32'h1000 + 32'(i * 16);
      step();
    end
    clear_inputs();
    checks++; if (bus2.redirect_cnt !== 2'd3 || bus.redirect_cnt !== 16'd5) begin
      failures++; $display("FAIL cnt_sat got=%0d/%0d want=3/5", bus2.redirect_cnt, bus.redirect_cnt); end
    checks++; if (bus.pc !== 32'h1040) begin failures++; $display("FAIL exc_last got=%h want=00001040", bus.pc); end
    bus.exc_valid = 1; bus.exc_vector = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    checks++; if (bus.pc_plus !== 32'h0) begin failures++; $display("FAIL wrap_plus got=%h want=00000000", bus.pc_plus); end
    step();
    checks++; if (bus.pc !== 32'h0 || bus.redirect !== 1'b0) begin
      failures++; $display("FAIL wrap_pc got=%h/%b want=00000000/0", bus.pc, bus.redirect); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_priority();
    test_stall_exc_overwrite();
    test_stall_jr_release();
    test_async_reset_sat_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
